// File: rtl/axilite_regfile_slave.sv
// AXI4-Lite slave terminating into NUM_REGS x 32-bit registers, with independent
// read/write channels, registered responses and an exported register image.
module axilite_regfile_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY,
  output logic [NUM_REGS*32-1:0]  regs_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS*4);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("axilite_regfile_slave: DATA_WIDTH must be 32");
    end
    if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
      $error("axilite_regfile_slave: NUM_REGS must be a power of two in 2..256");
    end
  endgenerate

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t wstate, wstate_next;
  rstate_t rstate, rstate_next;

  logic                    ready_en;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_in_range, rd_in_range;
  logic [IDX_W-1:0]        wr_idx, rd_idx;

  assign aw_hs = AXI_AWVALID && AXI_AWREADY;
  assign w_hs  = AXI_WVALID && AXI_WREADY;
  assign ar_hs = AXI_ARVALID && AXI_ARREADY;

  // A half already held is taken from its latch, otherwise straight from the bus.
  assign wr_addr     = (wstate == W_HAVE_AW) ? aw_addr : AXI_AWADDR;
  assign wr_data     = (wstate == W_HAVE_W) ? w_data : AXI_WDATA;
  assign wr_strb     = (wstate == W_HAVE_W) ? w_strb : AXI_WSTRB;
  assign wr_in_range = {1'b0, wr_addr} < ADDR_LIMIT;
  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign rd_in_range = {1'b0, AXI_ARADDR} < ADDR_LIMIT;
  assign rd_idx      = AXI_ARADDR[IDX_W+1:2];

  // READY stays low until the first edge after reset release.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      ready_en <= 1'b0;
      wstate   <= W_IDLE;
      rstate   <= R_IDLE;
    end else begin
      ready_en <= 1'b1;
      wstate   <= wstate_next;
      rstate   <= rstate_next;
    end
  end

  always_comb begin
    wstate_next = wstate;
    unique case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_next = W_RESP;
        else if (aw_hs)    wstate_next = W_HAVE_AW;
        else if (w_hs)     wstate_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)       wstate_next = W_RESP;
      W_HAVE_W:  if (aw_hs)      wstate_next = W_RESP;
      W_RESP:    if (AXI_BREADY) wstate_next = W_IDLE;
      default:                   wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_next = rstate;
    unique case (rstate)
      R_IDLE:  if (ar_hs)      rstate_next = R_RESP;
      R_RESP:  if (AXI_RREADY) rstate_next = R_IDLE;
      default:                 rstate_next = R_IDLE;
    endcase
  end

  always_comb begin
    AXI_AWREADY = ready_en && (wstate == W_IDLE || wstate == W_HAVE_W);
    AXI_WREADY  = ready_en && (wstate == W_IDLE || wstate == W_HAVE_AW);
    AXI_BVALID  = (wstate == W_RESP);
    AXI_ARREADY = ready_en && (rstate == R_IDLE);
    AXI_RVALID  = (rstate == R_RESP);
    commit      = (wstate != W_RESP) && (wstate_next == W_RESP);
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      aw_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      AXI_BRESP <= '0;
    end else begin
      if (aw_hs)  aw_addr <= AXI_AWADDR;
      if (w_hs) begin
        w_data <= AXI_WDATA;
        w_strb <= AXI_WSTRB;
      end
      if (commit) AXI_BRESP <= wr_in_range ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_in_range) begin
      for (int unsigned b = 0; b < DATA_WIDTH/8; b++)
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // Read samples the bank before this edge's commit, so same-edge reads see the old value.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      AXI_RDATA <= '0;
      AXI_RRESP <= '0;
    end else if (ar_hs) begin
      AXI_RDATA <= rd_in_range ? regs[rd_idx] : '0;
      AXI_RRESP <= rd_in_range ? 2'b00 : 2'b10;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_o[32*i +: 32] = regs[i];
  end

endmodule

// File: doc/axilite_regfile_slave.md
Name: axilite_regfile_slave

Overview:
- AXI4-Lite responder that terminates master transactions into a bank of NUM_REGS word registers.
- Independent read and write channels. AW and W may arrive in any order. Responses are registered with full backpressure.
- Sits behind any AXI-Lite master in the design; provides the slave end for register-mapped peripherals and bench memory.
- Also exports the full register image for hardware consumers.

Parameters:
- ADDR_WIDTH, 32, width of AXI_AWADDR and AXI_ARADDR.
- DATA_WIDTH, 32, data width; fixed at 32. Any other value is a compile-time error.
- NUM_REGS, 16, number of 32-bit registers; must be a power of two, 2 to 256.

Ports:
- AXI_ACLK  in  1  clock.
- AXI_ARESETN  in  1  asynchronous active-low reset.
- AXI_AWADDR  in  ADDR_WIDTH  write address.
- AXI_AWVALID  in  1 / AXI_AWREADY  out  1  write-address handshake.
- AXI_WDATA  in  32  write data.
- AXI_WSTRB  in  4  byte enables.
- AXI_WVALID  in  1 / AXI_WREADY  out  1  write-data handshake.
- AXI_BRESP  out  2  write response (00 OKAY, 10 SLVERR).
- AXI_BVALID  out  1 / AXI_BREADY  in  1  write-response handshake.
- AXI_ARADDR  in  ADDR_WIDTH  read address.
- AXI_ARVALID  in  1 / AXI_ARREADY  out  1  read-address handshake.
- AXI_RDATA  out  32  read data.
- AXI_RRESP  out  2  read response.
- AXI_RVALID  out  1 / AXI_RREADY  in  1  read-data handshake.
- regs_o  out  NUM_REGS*32  register image; register i occupies bits [32*i+31:32*i].

Behaviour:
- Reset:
  - All outputs 0, including READY signals and every register.
  - AWREADY, WREADY and ARREADY go 1 on the first clock edge after AXI_ARESETN deasserts.
  - Reset asserted mid-transaction drops the transaction, with no response and no register update.
- Decode:
  - Word index = ADDR[log2(NUM_REGS)+1:2]. ADDR[1:0] is ignored.
  - An address is in range only if ADDR < NUM_REGS*4. Otherwise the access is out of range.
- Handshake rule: a transfer occurs on an edge where VALID&&READY. The slave never waits for VALID before asserting READY.
- Write channel:
  - AW capture: on the AW handshake, latch the address into aw_held. AWREADY drops on that edge.
  - W capture: on the W handshake, latch data and strobe into w_held. WREADY drops on that edge.
  - Ordering: AW and W may complete on the same edge or in either order, with any gap between them.
  - Commit: on the edge where both are held (including both handshaking on the same edge):
    - In range: each byte with WSTRB[b]=1 is updated. WSTRB=0 commits nothing and still returns OKAY.
    - Out of range: the register bank is unchanged and BRESP=10.
    - BVALID=1 from that edge.
  - Hold: BVALID and BRESP stay stable until BREADY. AWREADY and WREADY stay 0 while BVALID=1.
  - Release: on the B handshake edge, BVALID goes 0 and held flags clear. AWREADY and WREADY go 1 on the same edge.
  - Throughput: minimum 2 cycles per write.
- Read channel:
  - Capture: on the AR handshake edge, RDATA gets the register value as of before that edge, and RRESP gets 00 (or 10 with RDATA=0 if out of range).
  - On that same edge RVALID goes 1 and ARREADY goes 0.
  - Hold: RDATA and RRESP stay stable until RREADY.
  - Release: on the R handshake edge, RVALID goes 0 and ARREADY goes 1.
  - Throughput: minimum 2 cycles per read.
- Simultaneous events:
  - A read and a write commit to the same register on the same edge: the read returns the old value.
  - The channels never stall each other.
- regs_o reflects committed values and updates on the commit edge.

Test Plan:
- Reset, then AW and W on the same edge: addr 0x08, data 0xDEADBEEF, WSTRB=F -> BVALID next cycle with BRESP=00. regs_o word 2 = 0xDEADBEEF. Read of 0x08 returns 0xDEADBEEF with RRESP=00, RVALID one cycle after AR.
- W three cycles before AW: data 0x12345678 to 0x04 -> WREADY 0 after the W handshake, commit on the AW edge, BRESP=00.
- Partial strobe: register 0x0C = 0xFFFFFFFF, write 0x00000000 with WSTRB=0101 -> readback 0xFF00FF00.
- Out of range: write 0x40 with NUM_REGS=16 -> BRESP=10 and no register changes. Read 0x40 -> RDATA=0, RRESP=10.
- Backpressure: BREADY and RREADY held 0 for 5 cycles -> BVALID, RVALID and data stay stable. AWREADY, WREADY and ARREADY stay 0 until the respective handshake.
- Same-edge read/write: 0x00 = 0x1, write 0x2 with AR to 0x00 on the commit edge -> RDATA=0x1. Next read returns 0x2.
- Reset asserted while BVALID=1 -> all outputs 0 immediately, registers 0, READY signals 1 one edge after release.
